// File: rtl/sc_regfile_pkg.sv
// Shared op-code encoding for the register bank write port; also used by the control unit encoder.
package sc_regfile_pkg;

   localparam int unsigned SC_OP_W = 2;

   typedef enum logic [SC_OP_W-1:0] {
      SC_OP_NOP  = 2'b00,
      SC_OP_LOAD = 2'b01,
      SC_OP_INC  = 2'b10,
      SC_OP_CLR  = 2'b11
   } sc_op_e;

endpackage

// File: rtl/sc_regfile_cell.sv
// One bank register: op mux, write select and INC carry-out. Updates on the falling clock edge.
module sc_regfile_cell
   import sc_regfile_pkg::*;
#(
   parameter int unsigned               DATAWIDTH_BUS    = 32,
   parameter logic [DATAWIDTH_BUS-1:0]  DATA_REGGEN_INIT = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_sel,
   input  logic [SC_OP_W-1:0]        wr_op,
   input  logic [DATAWIDTH_BUS-1:0]  wr_data,
   output logic [DATAWIDTH_BUS-1:0]  val_q,
   output logic [DATAWIDTH_BUS-1:0]  next_val_c,
   output logic                      carry_c
);

   logic [DATAWIDTH_BUS-1:0] val_d;
   sc_op_e                   op_c;

   assign op_c = sc_op_e'(wr_op);

   // next_val_c is what this register would take if selected; also feeds the bypass path
   always_comb begin
      next_val_c = val_q;
      carry_c    = &val_q;
      case (op_c)
         SC_OP_LOAD: next_val_c = wr_data;
         SC_OP_INC:  next_val_c = val_q + DATAWIDTH_BUS'(1);
         SC_OP_CLR:  next_val_c = '0;
         default:    next_val_c = val_q;
      endcase
      val_d = wr_sel ? next_val_c : val_q;
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) val_q <= DATA_REGGEN_INIT;
      else     val_q <= val_d;
   end

endmodule

// File: rtl/sc_regfile_bank.sv
// Register bank: one op-coded write port, two tri-stated read buses, registered INC overflow flag.
// Optional SC_REGFILE_BYPASS_EN forwards the pending write value onto matching read buses.
module sc_regfile_bank
   import sc_regfile_pkg::*;
#(
   parameter int unsigned               DATAWIDTH_BUS    = 32,
   parameter int unsigned               ADDRWIDTH_BUS    = 3,
   parameter int unsigned               NUM_REGS         = 8,
   parameter logic [DATAWIDTH_BUS-1:0]  DATA_REGGEN_INIT = '0
) (
   input  logic                      SC_RegFILE_CLOCK_50,
   input  logic                      SC_RegFILE_Reset_InHigh,
   input  logic [SC_OP_W-1:0]        SC_RegFILE_WriteOp_In,
   input  logic [ADDRWIDTH_BUS-1:0]  SC_RegFILE_WriteAddr_In,
   input  logic [DATAWIDTH_BUS-1:0]  SC_RegFILE_DataBUS_In,
   input  logic [ADDRWIDTH_BUS-1:0]  SC_RegFILE_ReadAddr_A_In,
   input  logic [ADDRWIDTH_BUS-1:0]  SC_RegFILE_ReadAddr_B_In,
   input  logic                      SC_RegFILE_ENABLE_BUS_A,
   input  logic                      SC_RegFILE_ENABLE_BUS_B,
   output logic [DATAWIDTH_BUS-1:0]  SC_RegFILE_DataBUS_Out_A,
   output logic [DATAWIDTH_BUS-1:0]  SC_RegFILE_DataBUS_Out_B,
   output logic                      SC_RegFILE_Overflow_OutHigh
);

   if (NUM_REGS < 1 || NUM_REGS > (1 << ADDRWIDTH_BUS)) begin : g_bad_num_regs
      $error("sc_regfile_bank: NUM_REGS must be 1..2**ADDRWIDTH_BUS");
   end

   logic [DATAWIDTH_BUS-1:0] reg_q      [NUM_REGS];
   logic [DATAWIDTH_BUS-1:0] next_val_c [NUM_REGS];
   logic [NUM_REGS-1:0]      carry_c;
   logic [NUM_REGS-1:0]      wr_sel_c;

   logic                     wr_valid_c;
   logic [DATAWIDTH_BUS-1:0] wr_next_c;
   logic                     wr_carry_c;
   logic                     fwd_en_c;
   logic [DATAWIDTH_BUS-1:0] rd_a_c;
   logic [DATAWIDTH_BUS-1:0] rd_b_c;
   logic                     ovf_q;
   logic                     ovf_d;

   for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_cell
      assign wr_sel_c[i] = (SC_RegFILE_WriteAddr_In == ADDRWIDTH_BUS'(i));

      sc_regfile_cell #(
         .DATAWIDTH_BUS    (DATAWIDTH_BUS),
         .DATA_REGGEN_INIT (DATA_REGGEN_INIT)
      ) u_cell (
         .clk        (SC_RegFILE_CLOCK_50),
         .rst        (SC_RegFILE_Reset_InHigh),
         .wr_sel     (wr_sel_c[i]),
         .wr_op      (SC_RegFILE_WriteOp_In),
         .wr_data    (SC_RegFILE_DataBUS_In),
         .val_q      (reg_q[i]),
         .next_val_c (next_val_c[i]),
         .carry_c    (carry_c[i])
      );
   end

   assign wr_valid_c = (32'(SC_RegFILE_WriteAddr_In) < NUM_REGS);

`ifdef SC_REGFILE_BYPASS_EN
   assign fwd_en_c = wr_valid_c && (sc_op_e'(SC_RegFILE_WriteOp_In) != SC_OP_NOP);
`else
   assign fwd_en_c = 1'b0;
`endif

   // Selected target's next value and carry; overflow only moves on a valid-address write
   always_comb begin
      wr_next_c  = '0;
      wr_carry_c = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (SC_RegFILE_WriteAddr_In == ADDRWIDTH_BUS'(i)) begin
            wr_next_c  = next_val_c[i];
            wr_carry_c = carry_c[i];
         end
      end
      ovf_d = ovf_q;
      if (wr_valid_c) begin
         case (sc_op_e'(SC_RegFILE_WriteOp_In))
            SC_OP_INC:  ovf_d = wr_carry_c;
            SC_OP_LOAD: ovf_d = 1'b0;
            SC_OP_CLR:  ovf_d = 1'b0;
            default:    ovf_d = ovf_q;
         endcase
      end
   end

   // Out-of-range read addresses return zero rather than X
   always_comb begin
      rd_a_c = '0;
      rd_b_c = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (SC_RegFILE_ReadAddr_A_In == ADDRWIDTH_BUS'(i)) rd_a_c = reg_q[i];
         if (SC_RegFILE_ReadAddr_B_In == ADDRWIDTH_BUS'(i)) rd_b_c = reg_q[i];
      end
      if (fwd_en_c && (SC_RegFILE_ReadAddr_A_In == SC_RegFILE_WriteAddr_In)) rd_a_c = wr_next_c;
      if (fwd_en_c && (SC_RegFILE_ReadAddr_B_In == SC_RegFILE_WriteAddr_In)) rd_b_c = wr_next_c;
   end

   always_ff @(negedge SC_RegFILE_CLOCK_50 or posedge SC_RegFILE_Reset_InHigh) begin
      if (SC_RegFILE_Reset_InHigh) ovf_q <= 1'b0;
      else                         ovf_q <= ovf_d;
   end

   assign SC_RegFILE_Overflow_OutHigh = ovf_q;
   assign SC_RegFILE_DataBUS_Out_A = SC_RegFILE_ENABLE_BUS_A ? rd_a_c : {DATAWIDTH_BUS{1'bz}};
   assign SC_RegFILE_DataBUS_Out_B = SC_RegFILE_ENABLE_BUS_B ? rd_b_c : {DATAWIDTH_BUS{1'bz}};

endmodule
